// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width default, one-hot unit selects, logic-op codes.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_CMP   = 4'b0010;
  localparam logic [3:0] OP_BOOL  = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;

  typedef enum logic [1:0] {
    BOOL_XOR  = 2'b00,
    BOOL_RSVD = 2'b01,
    BOOL_OR   = 2'b10,
    BOOL_AND  = 2'b11
  } bool_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter, purely combinational (0 cycles); no flow control.
// Left shifts reuse the right-shift network by reversing the operand on the way in and out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int W  = XLEN_DEFAULT,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  value,
  input  logic [SW-1:0] amount,
  input  logic          dir,
  input  logic          arith,
  output logic [W-1:0]  result
);

  logic [W-1:0] value_rev;
  logic [W-1:0] src;
  logic [W-1:0] shifted;
  logic [W-1:0] shifted_rev;
  logic         fill;

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign value_rev[i]   = value[W-1-i];
    assign shifted_rev[i] = shifted[W-1-i];
  end

  assign src  = dir ? value : value_rev;
  // Sign fill only applies to arithmetic right shifts; left shifts always fill with zero.
  assign fill = dir & arith & value[W-1];

  assign shifted = W'($signed({fill, src}) >>> amount);
  assign result  = dir ? shifted : shifted_rev;

endmodule

// File: rtl/alu.sv
// Registered integer ALU (add/sub, compare, logic, optional shift under ALU_SHIFT_EN), 1-cycle latency.
// No backpressure: a new result is captured on every rising edge.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_sub,
  input  logic [1:0]      i_bool_op,
  input  logic [3:0]      i_op_sel,
  input  logic            i_shift_dir,
  input  logic            i_cmp_sig,
  output logic [XLEN-1:0] o_result
);

  localparam int SW = $clog2(XLEN);

  logic            sub_en;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum_ext;
  logic            ult;
  logic            slt;
  logic            lt;
  logic [XLEN-1:0] bool_res;
  logic [XLEN-1:0] shift_res;
  logic [XLEN-1:0] result_d;
  logic [XLEN-1:0] result_q;

  // Compare always subtracts; only add/sub honours i_sub.
  assign sub_en  = (i_op_sel == OP_CMP) ? 1'b1 : i_sub;
  assign b_eff   = sub_en ? ~i_op_b : i_op_b;
  assign sum_ext = {1'b0, i_op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub_en};

  // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
  assign ult = ~sum_ext[XLEN];
  assign slt = (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]) ? i_op_a[XLEN-1] : sum_ext[XLEN-1];
  assign lt  = i_cmp_sig ? slt : ult;

  always_comb begin
    bool_res = '0;
    case (i_bool_op)
      BOOL_XOR: bool_res = i_op_a ^ i_op_b;
      BOOL_OR:  bool_res = i_op_a | i_op_b;
      BOOL_AND: bool_res = i_op_a & i_op_b;
      default:  bool_res = '0;
    endcase
  end

`ifdef ALU_SHIFT_EN
  alu_shifter #(
    .W  (XLEN),
    .SW (SW)
  ) u_shifter (
    .value  (i_op_a),
    .amount (i_op_b[SW-1:0]),
    .dir    (i_shift_dir),
    .arith  (i_sub),
    .result (shift_res)
  );
`else
  logic unused_shift_dir;
  assign unused_shift_dir = i_shift_dir;
  assign shift_res        = '0;
`endif

  // Selecting purely on i_op_sel keeps X on an idle unit's controls out of the result.
  always_comb begin
    result_d = '0;
    case (i_op_sel)
      OP_ADD:   result_d = sum_ext[XLEN-1:0];
      OP_CMP:   result_d = {{(XLEN-1){1'b0}}, lt};
      OP_BOOL:  result_d = bool_res;
      OP_SHIFT: result_d = shift_res;
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors, one-cycle latency, async reset and select decoding.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic [1:0]  bool_op;
  logic [3:0]  op_sel;
  logic        shift_dir;
  logic        cmp_sig;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  alu #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_sub       (sub),
    .i_bool_op   (bool_op),
    .i_op_sel    (op_sel),
    .i_shift_dir (shift_dir),
    .i_cmp_sig   (cmp_sig),
    .o_result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (result === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, result, exp);
    end
  endtask

  // Drive one operation, then sample one cycle later, just after the capturing edge.
  task automatic run(input string tag, input logic [3:0] sel, input logic [31:0] a,
                     input logic [31:0] b, input logic s, input logic [1:0] bo,
                     input logic dir, input logic sig, input logic [31:0] exp);
    op_sel    = sel;
    op_a      = a;
    op_b      = b;
    sub       = s;
    bool_op   = bo;
    shift_dir = dir;
    cmp_sig   = sig;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    rst       = 1'b1;
    op_a      = 32'd0;
    op_b      = 32'd0;
    sub       = 1'b0;
    bool_op   = 2'b00;
    op_sel    = OP_ADD;
    shift_dir = 1'b0;
    cmp_sig   = 1'b0;

    // Reset state, with inputs that would otherwise produce a nonzero result.
    op_a = 32'd7;
    op_b = 32'd9;
    @(posedge clk);
    #1;
    check("reset_hold", 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", 32'd16);

    // Add/sub
    run("add_1234_5678", OP_ADD, 32'd1234, 32'd5678, 1'b0, 2'b00, 1'b0, 1'b0, 32'd6912);
    run("sub_5_6",       OP_ADD, 32'd5,    32'd6,    1'b1, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF);
    run("sub_0_0",       OP_ADD, 32'd0,    32'd0,    1'b1, 2'b00, 1'b0, 1'b0, 32'd0);
    run("add_wrap",      OP_ADD, 32'hFFFF_FFFF, 32'd2, 1'b0, 2'b11, 1'b1, 1'b1, 32'd1);

    // Output must hold the previous value until the next edge.
    op_a = 32'd100;
    op_b = 32'd1;
    sub  = 1'b0;
    #1;
    check("latency_hold", 32'd1);
    @(posedge clk);
    #1;
    check("latency_update", 32'd101);

    // Logic ops on A=5, B=6
    run("xor", OP_BOOL, 32'd5, 32'd6, 1'b1, BOOL_XOR,  1'b0, 1'b0, 32'd3);
    run("rsvd", OP_BOOL, 32'd5, 32'd6, 1'b0, BOOL_RSVD, 1'b0, 1'b0, 32'd0);
    run("or",  OP_BOOL, 32'd5, 32'd6, 1'b0, BOOL_OR,   1'b0, 1'b0, 32'd7);
    run("and", OP_BOOL, 32'd5, 32'd6, 1'b1, BOOL_AND,  1'b1, 1'b1, 32'd4);

    // Compare: unsigned, then signed; i_sub deliberately varied to show it is ignored.
    run("ult_5_8",    OP_CMP, 32'd5, 32'd8, 1'b0, 2'b00, 1'b0, 1'b0, 32'd1);
    run("ult_8_5",    OP_CMP, 32'd8, 32'd5, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0);
    run("ult_8_8",    OP_CMP, 32'd8, 32'd8, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0);
    run("ult_8_min",  OP_CMP, 32'd8, 32'h8000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 32'd1);
    run("slt_5_m8",   OP_CMP, 32'd5, 32'hFFFF_FFF8, 1'b0, 2'b00, 1'b0, 1'b1, 32'd0);
    run("slt_m8_5",   OP_CMP, 32'hFFFF_FFF8, 32'd5, 1'b1, 2'b00, 1'b0, 1'b1, 32'd1);
    run("slt_8_min",  OP_CMP, 32'd8, 32'h8000_0000, 1'b0, 2'b00, 1'b0, 1'b1, 32'd0);
    run("slt_8_8",    OP_CMP, 32'd8, 32'd8, 1'b0, 2'b00, 1'b0, 1'b1, 32'd0);
    run("slt_m9_m8",  OP_CMP, 32'hFFFF_FFF7, 32'hFFFF_FFF8, 1'b0, 2'b00, 1'b0, 1'b1, 32'd1);

    // Shifter
`ifdef ALU_SHIFT_EN
    run("sll_8",      OP_SHIFT, 32'h0000_FFFF, 32'd8, 1'b0, 2'b00, 1'b0, 1'b0, 32'h00FF_FF00);
    run("srl_8",      OP_SHIFT, 32'h0000_FFFF, 32'd8, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_00FF);
    run("sra_8",      OP_SHIFT, 32'hF000_FFFF, 32'd8, 1'b1, 2'b00, 1'b1, 1'b0, 32'hFFF0_00FF);
    run("srl_neg_8",  OP_SHIFT, 32'hF000_FFFF, 32'd8, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00F0_00FF);
    run("sll_0",      OP_SHIFT, 32'h1234_5678, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h1234_5678);
    run("sra_0",      OP_SHIFT, 32'h8765_4321, 32'd0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h8765_4321);
    run("sll_31",     OP_SHIFT, 32'h0000_0003, 32'd31, 1'b0, 2'b00, 1'b0, 1'b0, 32'h8000_0000);
    run("sra_31",     OP_SHIFT, 32'h8000_0000, 32'd31, 1'b1, 2'b00, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run("srl_31",     OP_SHIFT, 32'h8000_0000, 32'd31, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0001);
    run("sll_hi_amt", OP_SHIFT, 32'h0000_0001, 32'hFFFF_FFE4, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0010);
`else
    run("shift_off",  OP_SHIFT, 32'h0000_FFFF, 32'd8, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0);
    run("shift_off_r", OP_SHIFT, 32'hF000_FFFF, 32'd8, 1'b1, 2'b00, 1'b1, 1'b0, 32'd0);
`endif

    // Illegal selects
    run("sel_0000", 4'b0000, 32'd5, 32'd6, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0);
    run("sel_0011", 4'b0011, 32'd5, 32'd6, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0);
    run("sel_1111", 4'b1111, 32'd5, 32'd6, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0);

    // Mid-stream reset: clears immediately, pending result is not replayed.
    run("pre_reset", OP_ADD, 32'd1234, 32'd5678, 1'b0, 2'b00, 1'b0, 1'b0, 32'd6912);
    op_a = 32'd40;
    op_b = 32'd2;
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 32'd0);
    rst = 1'b0;
    #1;
    check("reset_no_replay", 32'd0);
    @(posedge clk);
    #1;
    check("after_reset", 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
